laser_turret_emu: RTL and testbench

LASER_TURRET_EMU -- requirements
Module: laser_turret_emu

---
 rtl/laser_turret_emu.sv | 106 ++++++++++
 tb/tb_laser_turret_emu.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/laser_turret_emu.sv
// rtl/laser_turret_emu.sv - rotating laser turret emulator: quadrature encoder, index pulse, beacon photodiode
// Optional second beacon window: define LASER_EMU_BEACON2_EN.
module laser_turret_emu #(
  parameter logic [15:0] TICKS_PER_REV = 16'd1440
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dir,
  input  logic [15:0] step_div,
  input  logic [15:0] beacon_start,
  input  logic [15:0] beacon_end,
  input  logic [15:0] beacon2_start,
  input  logic [15:0] beacon2_end,
  output logic        Laser_cod_A,
  output logic        Laser_cod_B,
  output logic        Laser_sync,
  output logic        Laser_signal,
  output logic [15:0] angle
);

  localparam logic [15:0] LAST_ANGLE = TICKS_PER_REV - 16'd1;

  logic [15:0] prescaler;
  logic        step;
  logic        wrap;
  logic [15:0] angle_next;
  logic [1:0]  quad_next;
  logic        hit;

  // Window test; a window whose start exceeds its end wraps across angle 0.
  function automatic logic in_window(input logic [15:0] a,
                                     input logic [15:0] s,
                                     input logic [15:0] e);
    if (s <= e) return (a >= s) && (a <= e);
    else        return (a >= s) || (a <= e);
  endfunction

  // Step event: prescaler has reached the programmed period while rotating.
  // Using >= lets a lowered step_div take effect on the very next cycle.
  always_comb begin
    step = enable && (prescaler >= step_div);
  end

  // Next angle and wrap detection; dir only matters on a step.
  always_comb begin
    wrap       = dir ? (angle == LAST_ANGLE) : (angle == 16'd0);
    angle_next = angle;
    if (dir) angle_next = wrap ? 16'd0 : angle + 16'd1;
    else     angle_next = wrap ? LAST_ANGLE : angle - 16'd1;
  end

  // Quadrature sequence: forward 00->10->11->01->00, reverse walks it backwards.
  always_comb begin
    quad_next = {Laser_cod_A, Laser_cod_B};
    case ({Laser_cod_A, Laser_cod_B})
      2'b00:   quad_next = dir ? 2'b10 : 2'b01;
      2'b10:   quad_next = dir ? 2'b11 : 2'b00;
      2'b11:   quad_next = dir ? 2'b01 : 2'b10;
      default: quad_next = dir ? 2'b00 : 2'b11;
    endcase
  end

  // Beacon hit for the current angle; window 2 is ORed in only when built in.
`ifdef LASER_EMU_BEACON2_EN
  always_comb begin
    hit = in_window(angle, beacon_start, beacon_end) ||
          in_window(angle, beacon2_start, beacon2_end);
  end
`else
  wire unused_beacon2 = ^{beacon2_start, beacon2_end};
  always_comb begin
    hit = in_window(angle, beacon_start, beacon_end);
  end
`endif

  // Prescaler: counts enabled cycles, clears on each step, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset)       prescaler <= 16'd0;
    else if (step)   prescaler <= 16'd0;
    else if (enable) prescaler <= prescaler + 16'd1;
  end

  // Position and encoder channels advance together on a step; index pulse marks wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      angle       <= 16'd0;
      Laser_cod_A <= 1'b0;
      Laser_cod_B <= 1'b0;
      Laser_sync  <= 1'b0;
    end else begin
      Laser_sync <= step && wrap;
      if (step) begin
        angle                      <= angle_next;
        {Laser_cod_A, Laser_cod_B} <= quad_next;
      end
    end
  end

  // Photodiode output lags the angle by one cycle.
  always_ff @(posedge clk) begin
    if (reset) Laser_signal <= 1'b0;
    else       Laser_signal <= hit;
  end

endmodule

// File: tb/tb_laser_turret_emu.sv
// tb/tb_laser_turret_emu.sv - directed self-checking bench for laser_turret_emu (TICKS_PER_REV=8)
module tb_laser_turret_emu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        dir = 1'b1;
  logic [15:0] step_div = 16'd0;
  logic [15:0] beacon_start = 16'd5;
  logic [15:0] beacon_end = 16'd5;
  logic [15:0] beacon2_start = 16'd5;
  logic [15:0] beacon2_end = 16'd5;
  logic        Laser_cod_A;
  logic        Laser_cod_B;
  logic        Laser_sync;
  logic        Laser_signal;
  logic [15:0] angle;

  int n_cmp = 0;
  int n_fail = 0;

  laser_turret_emu #(.TICKS_PER_REV(16'd8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step_div(step_div),
    .beacon_start(beacon_start), .beacon_end(beacon_end),
    .beacon2_start(beacon2_start), .beacon2_end(beacon2_end),
    .Laser_cod_A(Laser_cod_A), .Laser_cod_B(Laser_cod_B),
    .Laser_sync(Laser_sync), .Laser_signal(Laser_signal), .angle(angle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; dir = 1'b1; step_div = 16'd0;
    beacon_start = 16'd0; beacon_end = 16'd7;
    reset = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (angle !== 16'd0) begin n_fail++; $display("FAIL reset_angle got %0d want 0", angle); end
    n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== 2'b00) begin n_fail++; $display("FAIL reset_ab got %b want 00", {Laser_cod_A, Laser_cod_B}); end
    n_cmp++; if (Laser_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %b want 0", Laser_sync); end
    n_cmp++; if (Laser_signal !== 1'b0) begin n_fail++; $display("FAIL reset_signal got %b want 0", Laser_signal); end
    reset = 1'b0;
  endtask

  task automatic test_forward_div3();
    logic [1:0] ab_exp [4];
    ab_exp[0] = 2'b10; ab_exp[1] = 2'b11; ab_exp[2] = 2'b01; ab_exp[3] = 2'b00;
    enable = 1'b1; dir = 1'b1; step_div = 16'd3;
    beacon_start = 16'd6; beacon_end = 16'd6;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        n_cmp++; if (angle !== 16'(k - 1)) begin n_fail++; $display("FAIL fwd_hold k=%0d got %0d want %0d", k, angle, k - 1); end
      end
      tick();
      n_cmp++; if (angle !== 16'(k)) begin n_fail++; $display("FAIL fwd_angle k=%0d got %0d want %0d", k, angle, k); end
      n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== ab_exp[k-1]) begin n_fail++; $display("FAIL fwd_ab k=%0d got %b want %b", k, {Laser_cod_A, Laser_cod_B}, ab_exp[k-1]); end
    end
  endtask

  task automatic test_wrap_forward();
    enable = 1'b1; dir = 1'b1; step_div = 16'd0;
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      tick();
      n_cmp++; if (angle !== 16'(n % 8)) begin n_fail++; $display("FAIL wrap_angle n=%0d got %0d want %0d", n, angle, n % 8); end
      n_cmp++; if (Laser_sync !== ((n % 8) == 0)) begin n_fail++; $display("FAIL wrap_sync n=%0d got %b want %b", n, Laser_sync, (n % 8) == 0); end
    end
  endtask

  task automatic test_reverse();
    enable = 1'b1; dir = 1'b0; step_div = 16'd0;
    do_reset();
    tick();
    n_cmp++; if (angle !== 16'd7) begin n_fail++; $display("FAIL rev_angle got %0d want 7", angle); end
    n_cmp++; if (Laser_sync !== 1'b1) begin n_fail++; $display("FAIL rev_sync got %b want 1", Laser_sync); end
    n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== 2'b01) begin n_fail++; $display("FAIL rev_ab got %b want 01", {Laser_cod_A, Laser_cod_B}); end
    tick();
    n_cmp++; if (angle !== 16'd6) begin n_fail++; $display("FAIL rev_angle2 got %0d want 6", angle); end
    n_cmp++; if (Laser_sync !== 1'b0) begin n_fail++; $display("FAIL rev_sync2 got %b want 0", Laser_sync); end
    n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== 2'b11) begin n_fail++; $display("FAIL rev_ab2 got %b want 11", {Laser_cod_A, Laser_cod_B}); end
  endtask

  task automatic test_window_wrap();
    logic [7:0] mask;
    mask = 8'b1110_0111;
    enable = 1'b1; dir = 1'b1; step_div = 16'd0;
    beacon_start = 16'd5; beacon_end = 16'd2;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      tick();
      n_cmp++; if (Laser_signal !== mask[(n - 1) % 8]) begin n_fail++; $display("FAIL win_wrap n=%0d got %b want %b", n, Laser_signal, mask[(n - 1) % 8]); end
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b1; dir = 1'b1; step_div = 16'd0;
    beacon_start = 16'd3; beacon_end = 16'd3;
    do_reset();
    tick(); tick(); tick();
    enable = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      n_cmp++; if (angle !== 16'd3) begin n_fail++; $display("FAIL hold_angle n=%0d got %0d want 3", n, angle); end
      n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== 2'b01) begin n_fail++; $display("FAIL hold_ab n=%0d got %b want 01", n, {Laser_cod_A, Laser_cod_B}); end
      n_cmp++; if (Laser_sync !== 1'b0) begin n_fail++; $display("FAIL hold_sync n=%0d got %b want 0", n, Laser_sync); end
    end
    n_cmp++; if (Laser_signal !== 1'b1) begin n_fail++; $display("FAIL hold_signal got %b want 1", Laser_signal); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (angle !== 16'd0) begin n_fail++; $display("FAIL hold_rst_angle got %0d want 0", angle); end
    n_cmp++; if ({Laser_cod_A, Laser_cod_B} !== 2'b00) begin n_fail++; $display("FAIL hold_rst_ab got %b want 00", {Laser_cod_A, Laser_cod_B}); end
    n_cmp++; if (Laser_signal !== 1'b0) begin n_fail++; $display("FAIL hold_rst_signal got %b want 0", Laser_signal); end
    n_cmp++; if (Laser_sync !== 1'b0) begin n_fail++; $display("FAIL hold_rst_sync got %b want 0", Laser_sync); end
  endtask

  task automatic test_div_change_and_mid_reset();
    enable = 1'b1; dir = 1'b1; step_div = 16'd5;
    beacon_start = 16'd6; beacon_end = 16'd6;
    do_reset();
    tick(); tick();
    n_cmp++; if (angle !== 16'd0) begin n_fail++; $display("FAIL div_pre got %0d want 0", angle); end
    step_div = 16'd1;
    tick();
    n_cmp++; if (angle !== 16'd1) begin n_fail++; $display("FAIL div_lower got %0d want 1", angle); end
    step_div = 16'd3;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (angle !== 16'd0) begin n_fail++; $display("FAIL midrst_hold c=%0d got %0d want 0", c, angle); end
    end
    tick();
    n_cmp++; if (angle !== 16'd1) begin n_fail++; $display("FAIL midrst_step got %0d want 1", angle); end
  endtask

  task automatic test_beacon2();
    logic [7:0] mask;
`ifdef LASER_EMU_BEACON2_EN
    mask = 8'b0011_0010;
`else
    mask = 8'b0000_0010;
`endif
    enable = 1'b1; dir = 1'b1; step_div = 16'd0;
    beacon_start = 16'd1; beacon_end = 16'd1;
    beacon2_start = 16'd4; beacon2_end = 16'd5;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_cmp++; if (Laser_signal !== mask[(n - 1) % 8]) begin n_fail++; $display("FAIL beacon2 n=%0d got %b want %b", n, Laser_signal, mask[(n - 1) % 8]); end
    end
  endtask

  initial begin
    test_reset();
    test_forward_div3();
    test_wrap_forward();
    test_reverse();
    test_window_wrap();
    test_enable_hold();
    test_div_change_and_mid_reset();
    test_beacon2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
